// File: rtl/button_pulser.sv
// Multi-channel button conditioner: synchroniser, debounce filter, press pulse
// and optional auto-repeat per channel, all channels fully independent.
module button_pulser #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] pulse_out,
    output logic [N_CH-1:0] held_out,
    output logic            pulse_any
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

    logic [N_CH-1:0] w_pulse_vec;
    logic            r_pulse_any;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DW-1:0]          r_cnt;
        logic                   r_st;
        logic [RW-1:0]          r_rcnt;
        state_t                 r_state;
        logic                   r_pulse;
        logic                   w_s;
        logic                   w_st_nxt;
        logic                   w_pulse;

        assign w_s = r_sync[SYNC_STAGES-1];

        // The FSM looks at the debounced level as it will be after this edge,
        // so the press pulse lands on the same edge that held_out rises.
        assign w_st_nxt = (w_s != r_st && r_cnt == DB_LAST) ? w_s : r_st;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_st   <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], button_in[g]};
                r_st   <= w_st_nxt;
                if (w_s == r_st || r_cnt == DB_LAST)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + DW'(1);
            end
        end

        always_comb begin
            w_pulse = 1'b0;
            case (r_state)
                S_IDLE:   w_pulse = w_st_nxt & ~r_st;
                S_WAIT:   w_pulse = w_st_nxt & repeat_en[g] & (r_rcnt == DELAY_LAST);
                S_REPEAT: w_pulse = w_st_nxt & repeat_en[g] & (r_rcnt == RATE_LAST);
                default:  w_pulse = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= S_IDLE;
                r_rcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_pulse;
                case (r_state)
                    S_IDLE: begin
                        r_rcnt <= '0;
                        if (w_st_nxt && !r_st) r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (!w_st_nxt) begin
                            r_state <= S_IDLE;
                            r_rcnt  <= '0;
                        end else if (!repeat_en[g]) begin
                            r_rcnt <= '0;
                        end else if (r_rcnt == DELAY_LAST) begin
                            r_rcnt  <= '0;
                            r_state <= S_REPEAT;
                        end else begin
                            r_rcnt <= r_rcnt + RW'(1);
                        end
                    end
                    S_REPEAT: begin
                        if (!w_st_nxt) begin
                            r_state <= S_IDLE;
                            r_rcnt  <= '0;
                        end else if (!repeat_en[g]) begin
                            r_rcnt  <= '0;
                            r_state <= S_WAIT;
                        end else if (r_rcnt == RATE_LAST) begin
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + RW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end

        assign w_pulse_vec[g] = w_pulse;
        assign pulse_out[g]   = r_pulse;
        assign held_out[g]    = r_st;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pulse_any <= 1'b0;
        else        r_pulse_any <= |w_pulse_vec;
    end

    assign pulse_any = r_pulse_any;
endmodule

// File: doc/button_pulser.md
Name: button_pulser

Overview:
- Multi-channel button conditioner that generalises the single-button one-shot into a per-channel pipeline: synchroniser, debounce filter, one-cycle press pulse and optional auto-repeat while held.
- Drives game inputs such as cursor movement and reset.
- One press yields exactly one move. A held button with repeat enabled yields a controlled stream of moves.

Parameters:
- N_CH, 4: number of independent button channels.
- SYNC_STAGES, 2: flip-flops in each input synchroniser; legal values are ≥2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a new level must persist before it is accepted; legal values are ≥1.
- REPEAT_DELAY, 16: cycles from the initial press pulse to the first repeat pulse; legal values are ≥2.
- REPEAT_RATE, 4: cycles between successive repeat pulses; legal values are ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- button_in  input  N_CH  raw asynchronous button levels, 1 = pressed.
- repeat_en  input  N_CH  per-channel auto-repeat enable; synchronous, sampled every cycle.
- pulse_out  output  N_CH  registered one-cycle pulse per accepted press or repeat.
- held_out  output  N_CH  registered debounced level per channel.
- pulse_any  output  1  registered OR of all pulse_out bits.

Behaviour:
- Reset: reset low clears every flop immediately, with no clock required. This covers the synchroniser chains, debounced state, debounce counters, repeat counters and FSMs (→IDLE). pulse_out, held_out and pulse_any read 0 while reset is low and in the first cycle after release.
- Channels are fully independent. No arbitration is applied; any number of pulse_out bits may be high in the same cycle.
- Synchroniser: button_in[i] passes through SYNC_STAGES flops; the last stage output is s[i].
- Debounce, per channel. State is st (the debounced level) and cnt, a $clog2(DEBOUNCE_CYCLES+1)-bit counter.
  - If s == st: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: st ← s and cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is discarded and the count restarts.
  - held_out = st.
- Press latency: button_in is first sampled high at edge k and stays high. Then st and pulse_out rise after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1; with defaults this is edge k+5. Release follows the same latency for held_out falling, and release never pulses.
- Repeat FSM, per channel, with states IDLE, WAIT, REPEAT. rcnt is a $clog2(max(REPEAT_DELAY,REPEAT_RATE))-bit counter.
  - IDLE: when st goes 0→1, assert pulse_out for 1 cycle, rcnt ← 0, go to WAIT.
  - WAIT: if st==0 go to IDLE. Else if repeat_en==0, hold rcnt at 0. Else if rcnt == REPEAT_DELAY-1, pulse, rcnt ← 0, go to REPEAT. Else rcnt ← rcnt+1.
  - REPEAT: if st==0 go to IDLE. Else if repeat_en==0, rcnt ← 0 and go to WAIT. Else if rcnt == REPEAT_RATE-1, pulse and rcnt ← 0. Else rcnt ← rcnt+1.
  - Resulting timing: the first repeat pulse is REPEAT_DELAY cycles after the initial pulse, and later pulses are every REPEAT_RATE cycles.
- Pulse spacing: because REPEAT_DELAY and REPEAT_RATE are both ≥2, pulse_out is never high for two consecutive cycles.
- pulse_any is computed from the next-state pulse vector, so it is cycle-aligned with pulse_out.
- Boundary conditions:
  - Release on the same edge that a repeat would fire: IDLE wins and no pulse is generated.
  - repeat_en rising while held in WAIT: the REPEAT_DELAY countdown starts fresh.
  - A button held through reset release is treated as a new press and produces one pulse after the normal press latency.
  - Reset asserted mid-debounce or mid-repeat aborts the operation and leaves no pending pulse.
  - Counter rollover cannot occur, since every counter is cleared at its terminal value.

Test Plan:
- Single press, 5 cycles high, repeat_en=0, defaults; button_in[0] rises at edge 10 → pulse_out[0]=1 only after edge 15, held_out[0]=1 from edge 15 to edge 19, pulse_any matches pulse_out[0], and the other channels stay 0.
- Glitch rejection: button_in[1] high for 3 cycles, low for 1, high for 3 → no pulse and held_out[1] stays 0. Then high for 4 cycles → exactly one pulse.
- Auto-repeat: repeat_en[2]=1, button_in[2] held 50 cycles with the initial pulse at cycle P → pulses at P, P+16, P+20, P+24, …, each 1 cycle wide, and no pulse after the debounced release.
- Toggle repeat_en mid-hold: repeat_en[2] goes 1→0 at P+18 and back to 1 at P+30 → no pulses in P+19..P+45, next pulse at P+46.
- Simultaneous channels: all 4 buttons pressed on the same edge → all pulse_out bits high in the same single cycle and pulse_any=1 for 1 cycle.
- Async reset: reset driven low between clock edges during repeat → all outputs 0 immediately. Button still held at reset release → one pulse 6 edges later, with the same timing as a fresh press.
